// File: rtl/bmatch_pkg.sv
// Shared types and helpers for the boolean-matching pattern checker.
package bmatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_RSP_LAT = 7;
  // Select vectors are zero-extended to this width before field extraction.
  localparam int SEL_VEC_W = 64;

  function automatic int unsigned sel_field(input logic [SEL_VEC_W-1:0] vec,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [SEL_VEC_W-1:0] sh;
    sh = (vec >> (idx * w)) & ((SEL_VEC_W'(1) << w) - SEL_VEC_W'(1));
    return sh[31:0];
  endfunction

endpackage

// File: rtl/bmatch_perm_map.sv
// Combinational permute-and-negate: dst[j] = src[sel field j] ^ neg[j].
// Select values outside 0..N-1 fall back to index 0.
module bmatch_perm_map
  import bmatch_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]    src,
  input  logic [N*SW-1:0] sel,
  input  logic [N-1:0]    neg,
  output logic [N-1:0]    dst
);

  logic [SEL_VEC_W-1:0] sel_ext;
  assign sel_ext = SEL_VEC_W'(sel);

  always_comb begin
    int unsigned f;
    logic [N-1:0] sh;
    f   = 0;
    sh  = '0;
    dst = '0;
    for (int j = 0; j < N; j++) begin
      f = sel_field(sel_ext, j, SW);
      if (f >= N) f = 0;
      sh     = src >> f;
      dst[j] = sh[0] ^ neg[j];
    end
  end

endmodule

// File: rtl/bmatch_pattern_checker.sv
// Exhaustive stimulus/response checker: drives every input pattern into
// circuits A and B (B through an input map) and compares outputs via an output map.
module bmatch_pattern_checker
  import bmatch_pkg::*;
#(
  parameter int NI      = 4,
  parameter int NO      = 2,
  parameter int RSP_LAT = 1,
  parameter int SW      = (NI > 1) ? $clog2(NI) : 1,
  parameter int OW      = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NI*SW-1:0] in_sel,
  input  logic [NI-1:0]    in_neg,
  input  logic [NO*OW-1:0] out_sel,
  input  logic [NO-1:0]    out_neg,
  output logic [NI-1:0]    pat_a,
  output logic [NI-1:0]    pat_b,
  output logic             pat_valid,
  input  logic [NO-1:0]    resp_a,
  input  logic [NO-1:0]    resp_b,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [NI-1:0]    fail_pat,
  output logic [1:0]       dbg_state
);

  localparam logic [NI:0] LAST_CNT   = {1'b0, {NI{1'b1}}};
  localparam logic [2:0]  DRAIN_LAST = (RSP_LAT > 0) ? 3'(RSP_LAT - 1) : 3'd0;

  state_t state_q, state_d;
  logic [NI:0]      cnt_q;
  logic [2:0]       drain_q;
  logic [NI*SW-1:0] cfg_in_sel;
  logic [NI-1:0]    cfg_in_neg;
  logic [NO*OW-1:0] cfg_out_sel;
  logic [NO-1:0]    cfg_out_neg;
  logic             pass_q;
  logic             match_q;
  logic [NI-1:0]    fail_pat_q;

  logic             run;
  logic [NI-1:0]    mapped_in;
  logic [NO-1:0]    exp_b;
  logic             chk_valid;
  logic [NI-1:0]    chk_pat;
  logic             fail_now;
  logic             first_fail;

  // Handshake: pat_valid qualifies pat_a/pat_b for exactly one cycle each;
  // there is no ready, the circuits under test must accept a pattern every cycle.
  assign run       = (state_q == RUN);
  assign pat_valid = run;
  assign pat_a     = run ? cnt_q[NI-1:0] : '0;
  assign pat_b     = run ? mapped_in : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign match     = match_q;
  assign fail_pat  = fail_pat_q;
  assign dbg_state = state_q;

  bmatch_perm_map #(.N(NI), .SW(SW)) u_in_map (
    .src (cnt_q[NI-1:0]),
    .sel (cfg_in_sel),
    .neg (cfg_in_neg),
    .dst (mapped_in)
  );

  // Expected B outputs built from A: resp_a[sel[k]] ^ neg[k].
  bmatch_perm_map #(.N(NO), .SW(OW)) u_out_map (
    .src (resp_a),
    .sel (cfg_out_sel),
    .neg (cfg_out_neg),
    .dst (exp_b)
  );

  generate
    if (RSP_LAT == 0) begin : g_nolat
      assign chk_valid = pat_valid;
      assign chk_pat   = pat_a;
    end else begin : g_lat
      logic [RSP_LAT-1:0] tag_q;
      logic [NI-1:0]      tpat_q [RSP_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_q <= '0;
          for (int i = 0; i < RSP_LAT; i++) tpat_q[i] <= '0;
        end else begin
          tag_q[0]  <= pat_valid;
          tpat_q[0] <= pat_a;
          for (int i = 1; i < RSP_LAT; i++) begin
            tag_q[i]  <= tag_q[i-1];
            tpat_q[i] <= tpat_q[i-1];
          end
        end
      end
      assign chk_valid = tag_q[RSP_LAT-1];
      assign chk_pat   = tpat_q[RSP_LAT-1];
    end
  endgenerate

  assign fail_now   = chk_valid && (exp_b != resp_b);
  assign first_fail = fail_now && pass_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fail_now || cnt_q == LAST_CNT) state_d = (RSP_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_q == DRAIN_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      cfg_in_sel  <= '0;
      cfg_in_neg  <= '0;
      cfg_out_sel <= '0;
      cfg_out_neg <= '0;
      pass_q      <= 1'b0;
      match_q     <= 1'b0;
      fail_pat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cfg_in_sel  <= in_sel;
        cfg_in_neg  <= in_neg;
        cfg_out_sel <= out_sel;
        cfg_out_neg <= out_neg;
        cnt_q       <= '0;
        pass_q      <= 1'b1;
        match_q     <= 1'b0;
      end
      if (run) cnt_q <= cnt_q + (NI+1)'(1);
      drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : 3'd0;
      if (first_fail) begin
        pass_q     <= 1'b0;
        fail_pat_q <= chk_pat;
      end
      // The verdict includes a failure seen on the very cycle DONE is entered.
      if (state_d == DONE && state_q != DONE) match_q <= pass_q && !first_fail;
    end
  end

endmodule

// File: tb/tb_bmatch_pattern_checker.sv
// Directed, table-driven bench for bmatch_pattern_checker with a registered
// model of circuits A and B (RSP_LAT=1).
module tb_bmatch_pattern_checker;

  localparam int NI = 4;
  localparam int NO = 2;
  localparam int RSP_LAT = 1;
  localparam int SW = 2;
  localparam int OW = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NI*SW-1:0] in_sel;
  logic [NI-1:0]    in_neg;
  logic [NO*OW-1:0] out_sel;
  logic [NO-1:0]    out_neg;
  logic [NI-1:0]    pat_a, pat_b, fail_pat;
  logic             pat_valid, busy, done, match;
  logic [NO-1:0]    resp_a, resp_b;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int done_cnt = 0;
  logic [NI-1:0]    exp_q[$];
  logic [NI*SW-1:0] mdl_in_sel;
  logic [NI-1:0]    mdl_in_neg;

  typedef struct {
    logic [NI*SW-1:0] in_sel;
    logic [NI-1:0]    in_neg;
    logic [NO*OW-1:0] out_sel;
    logic [NO-1:0]    out_neg;
    int               mode;
    logic             exp_match;
    logic [NI-1:0]    exp_fail;
    int               exp_npat;
    int               exp_done;
  } vec_t;

  vec_t vecs[8];

  bmatch_pattern_checker #(.NI(NI), .NO(NO), .RSP_LAT(RSP_LAT), .SW(SW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_sel(in_sel), .in_neg(in_neg), .out_sel(out_sel), .out_neg(out_neg),
    .pat_a(pat_a), .pat_b(pat_b), .pat_valid(pat_valid),
    .resp_a(resp_a), .resp_b(resp_b),
    .busy(busy), .done(done), .match(match), .fail_pat(fail_pat),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / circuit models ----------------
  always #5 clk = ~clk;

  function automatic logic [NO-1:0] fa(input logic [NI-1:0] p);
    return {p[3] | p[0], p[3] & p[0]};
  endfunction

  function automatic logic [NO-1:0] fb(input logic [NI-1:0] p, input int m);
    case (m)
      1:       return {p[3] | ~p[0], p[3] & ~p[0]};
      2:       return {p[0] | p[3], p[0] & p[3]};
      default: return {p[3] | p[0], p[3] & p[0]};
    endcase
  endfunction

  function automatic logic [NI-1:0] map_in(input logic [NI-1:0] p,
                                           input logic [NI*SW-1:0] sel,
                                           input logic [NI-1:0] neg);
    logic [NI-1:0] r;
    logic [SW-1:0] idx;
    r = '0;
    for (int j = 0; j < NI; j++) begin
      idx  = sel[j*SW +: SW];
      r[j] = p[idx] ^ neg[j];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    resp_a <= fa(pat_a);
    resp_b <= fb(pat_b, mode);
  end

  always @(negedge clk) if (done) done_cnt++;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [NI-1:0] e;
    if (!rst && pat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pat_extra: got pattern %0h expected none", pat_a);
      end else begin
        e = exp_q.pop_front();
        check("pat_a", 32'(pat_a), 32'(e));
        check("pat_b", 32'(pat_b), 32'(map_in(e, mdl_in_sel, mdl_in_neg)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input vec_t v);
    @(posedge clk);
    #1;
    in_sel = v.in_sel; in_neg = v.in_neg; out_sel = v.out_sel; out_neg = v.out_neg;
    mdl_in_sel = v.in_sel; mdl_in_neg = v.in_neg;
    mode = v.mode;
    for (int p = 0; p < v.exp_npat; p++) exp_q.push_back(NI'(p));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int got;
    got = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_run", 32'(busy), 32'd1);
      if (done) begin
        got = n;
        break;
      end
    end
    check("done_cycle", 32'(got), 32'(exp_cyc));
  endtask

  task automatic run_vec(input vec_t v);
    launch(v);
    wait_done(v.exp_done);
    check("match", 32'(match), 32'(v.exp_match));
    if (!v.exp_match) check("fail_pat", 32'(fail_pat), 32'(v.exp_fail));
    check("pats_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("match_hold", 32'(match), 32'(v.exp_match));
  endtask

  // ---------------- test ----------------
  initial begin
    int snap;
    vecs[0] = '{8'hE4, 4'h0, 2'b10, 2'b00, 0, 1'b1, 4'h0, 16, 18}; // identity
    vecs[1] = '{8'hE4, 4'h0, 2'b01, 2'b00, 0, 1'b0, 4'h1,  3,  5}; // outputs swapped
    vecs[2] = '{8'hE4, 4'h0, 2'b10, 2'b11, 0, 1'b0, 4'h0,  2,  4}; // both outputs negated
    vecs[3] = '{8'hE4, 4'h1, 2'b10, 2'b00, 1, 1'b1, 4'h0, 16, 18}; // B uses ~i0
    vecs[4] = '{8'h27, 4'h0, 2'b10, 2'b00, 2, 1'b1, 4'h0, 16, 18}; // B swaps i0/i3
    vecs[5] = '{8'hE4, 4'h0, 2'b10, 2'b00, 2, 1'b1, 4'h0, 16, 18}; // same B, identity
    vecs[6] = '{8'h64, 4'h0, 2'b10, 2'b00, 0, 1'b0, 4'h2,  4,  6}; // B3<-A1, late fail
    vecs[7] = '{8'hE4, 4'h2, 2'b10, 2'b00, 0, 1'b1, 4'h0, 16, 18}; // negate unused input

    rst = 1'b1; start = 1'b0;
    in_sel = '0; in_neg = '0; out_sel = '0; out_neg = '0;
    mdl_in_sel = '0; mdl_in_neg = '0;
    #3;
    check("rst_pat_a", 32'(pat_a), 32'd0);
    check("rst_pat_b", 32'(pat_b), 32'd0);
    check("rst_pat_valid", 32'(pat_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_fail_pat", 32'(fail_pat), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in cycle 7 of a run aborts it immediately, no done pulse.
    launch(vecs[0]);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_pat_valid", 32'(pat_valid), 32'd0);
    check("abort_pat_a", 32'(pat_a), 32'd0);
    check("abort_pat_b", 32'(pat_b), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_match", 32'(match), 32'd0);
    check("abort_fail_pat", 32'(fail_pat), 32'd0);
    exp_q.delete();
    snap = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(snap));
    run_vec(vecs[0]);

    // start held through the run, config pins scrambled after capture,
    // start toggled in DRAIN: exactly one check.
    @(posedge clk);
    #1;
    in_sel = 8'hE4; in_neg = 4'h0; out_sel = 2'b10; out_neg = 2'b00;
    mdl_in_sel = 8'hE4; mdl_in_neg = 4'h0; mode = 0;
    for (int p = 0; p < 16; p++) exp_q.push_back(NI'(p));
    snap = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    in_sel = 8'h1B; in_neg = 4'hF; out_sel = 2'b01; out_neg = 2'b11;
    repeat (16) @(posedge clk);
    #1;
    check("hold_drain_state", 32'(dbg_state), 32'd2);
    check("hold_drain_valid", 32'(pat_valid), 32'd0);
    start = 1'b0;
    #2 start = 1'b1;
    @(posedge clk);
    #1;
    check("hold_done", 32'(done), 32'd1);
    check("hold_match", 32'(match), 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_one_done", 32'(done_cnt - snap), 32'd1);
    check("hold_idle", 32'(busy), 32'd0);
    check("hold_pats_left", 32'(exp_q.size()), 32'd0);

    // A fresh start from IDLE begins a new, independent check.
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bmatch_pattern_checker.md
Name: bmatch_pattern_checker

Overview:
- Sequential stimulus/response engine for the boolean-matching flow.
- Drives exhaustive input patterns into two candidate circuits: circuit A directly, circuit B through a candidate input permutation/negation.
- Reads back both output vectors and compares them through a candidate output permutation/negation.
- Reports match, or the first failing pattern. Used to confirm a match produced by the solver against gate-level netlists in simulation/emulation.

Parameters:
- NI, 4, number of primary inputs per circuit (1..16).
- NO, 2, number of primary outputs per circuit (1..16).
- RSP_LAT, 1, cycles from pattern drive to response sample (0..7).
- SW, $clog2(NI) (min 1), width of one input-select field.
- OW, $clog2(NO) (min 1), width of one output-select field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a check; accepted only in IDLE.
- in_sel  in  NI*SW  field j = index of the A input that feeds B input j.
- in_neg  in  NI  bit j inverts B input j.
- out_sel  in  NO*OW  field k = index of the A output compared with B output k.
- out_neg  in  NO  bit k inverts B output k before compare.
- pat_a  out  NI  pattern to circuit A.
- pat_b  out  NI  mapped pattern to circuit B.
- pat_valid  out  1  pat_a/pat_b carry a live pattern.
- resp_a  in  NO  circuit A outputs.
- resp_b  in  NO  circuit B outputs.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse at end of check.
- match  out  1  result; valid from the done pulse until the next start.
- fail_pat  out  NI  first failing pat_a value; valid when match=0.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pat_a=0, pat_b=0, pat_valid=0, busy=0, done=0, match=0, fail_pat=0.
  - Pipeline tags and counter cleared.
  - Reset mid-check aborts with no done pulse.
- States and transitions:
  - IDLE: start=1 captures in_sel/in_neg/out_sel/out_neg into registers. Next state RUN; cnt=0; match cleared. Config changes after capture have no effect.
  - RUN: pat_valid=1, pat_a=cnt, pat_b[j]=pat_a[cfg_in_sel[j]]^cfg_in_neg[j]. cnt increments every cycle.
    - If cnt=2^NI-1 is issued, go to DRAIN.
    - If a mismatch is detected, go to DRAIN immediately and stop issuing (pat_valid=0 from the next cycle).
  - DRAIN: pat_valid=0. Stay RSP_LAT cycles so in-flight responses are compared; with RSP_LAT=0, DRAIN lasts 0 cycles. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE. start is ignored while busy.
- Response alignment:
  - A valid tag and the pattern value go through an RSP_LAT-deep shift register. Tag i qualifies resp_a/resp_b sampled RSP_LAT cycles after pattern i is driven.
  - RSP_LAT=0 samples in the same cycle.
- Compare rule: pattern fails if any k has resp_b[k]^cfg_out_neg[k] != resp_a[cfg_out_sel[k]].
  - On the first failure: latch fail_pat from the tag pipeline, clear the internal pass flag, ignore later failures.
- match = pass flag at the done pulse.
- Out-of-range select values (>=NI or >=NO) are treated as index 0; no error is flagged.
- Full pass, start accepted at cycle 0: done at cycle 2^NI+RSP_LAT+1.
- cnt is NI+1 bits wide, so the wrap from 2^NI-1 is never ambiguous.
- A mismatch and the last pattern in the same cycle: the mismatch wins, fail_pat is recorded, and DRAIN is entered once.

Decomposition:
- Package bmatch_pkg: state enum (IDLE, RUN, DRAIN, DONE), helper function for field extraction from a packed select vector, constant MAX_RSP_LAT=7.
- One sub-module, bmatch_perm_map: combinational permute-and-negate, parameterised width and select width. Instantiated twice: inputs (NI) and outputs (NO, compare side).

Test Plan:
Bench model for all scenarios: circuit A has o0=i3&i0, o1=i3|i0. RSP_LAT=1, response registers one cycle.
- Identity config (in_sel={3,2,1,0}, in_neg=0, out_sel={1,0}, out_neg=0), B=A, start at cycle 0 -> 16 patterns 0..15 issued; done at cycle 18; match=1.
- Outputs swapped (out_sel={0,1}), B=A -> pattern 0 passes; pattern 1 fails (A: o0=0, o1=1). fail_pat=1, match=0, pat_valid drops after pattern 2, done 2 cycles later.
- B computes o0=i3&~i0, o1=i3|~i0; in_neg=4'b0001, identity selects -> match=1.
- B has i0 and i3 swapped internally; in_sel maps B0<-A3, B3<-A0 -> match=1. Same B with identity selects also gives match=1 (both functions symmetric).
- rst asserted at cycle 7 of a run -> all outputs zero immediately; no done; a new start then completes a normal pass.
- start held high through the whole run and toggled in DRAIN -> exactly one check and one done pulse. A start after returning to IDLE begins a new check.
